// File: rtl/cq_parser_mb.sv
// Completer-request (CQ) stream parser: splits each TLP into a decoded request
// descriptor and, for memory writes, a payload stream with per-DW lane enables.
module cq_parser_mb #(
  parameter int DATA_WIDTH  = 256,
  parameter int TUSER_WIDTH = 85,
  parameter int BAR0_SIZE   = 16
) (
  input  logic                     user_clk,
  input  logic                     user_reset_n,

  input  logic [DATA_WIDTH-1:0]    m_axis_cq_tdata,
  input  logic                     m_axis_cq_tvalid,
  input  logic [TUSER_WIDTH-1:0]   m_axis_cq_tuser,
  input  logic [DATA_WIDTH/32-1:0] m_axis_cq_tkeep,
  input  logic                     m_axis_cq_tlast,
  output logic                     m_axis_cq_tready,

  output logic                     req_valid,
  input  logic                     req_ready,
  output logic [3:0]               req_type,
  output logic [BAR0_SIZE-1:0]     req_addr,
  output logic [10:0]              req_dw_count,
  output logic [2:0]               req_bar_id,
  output logic [15:0]              req_requester_id,
  output logic [7:0]               req_tag,
  output logic [2:0]               req_tc,
  output logic [6:0]               req_lower_addr,

  output logic                     wr_valid,
  input  logic                     wr_ready,
  output logic [DATA_WIDTH-1:0]    wr_data,
  output logic [DATA_WIDTH/32-1:0] wr_dw_en,
  output logic                     wr_last,

  output logic [15:0]              err_unsupported_cnt,
  output logic                     err_malformed
);

  localparam int KEEP_WIDTH = DATA_WIDTH / 32;
  // The first beat carries the 4-DW descriptor in lanes 0..3; only the rest is payload.
  localparam logic [KEEP_WIDTH-1:0] PAYLOAD_LANES = {{(KEEP_WIDTH-4){1'b1}}, 4'b0000};
  localparam logic [3:0] TYPE_MEM_RD = 4'b0000;
  localparam logic [3:0] TYPE_MEM_WR = 4'b0001;

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    PAYLOAD,
    DISCARD
  } state_t;

  state_t state;
  logic   run;
  logic   beat;
  logic   req_done;
  logic   wr_done;
  logic   is_request;

  logic [11:0]           dw_seen;
  logic [11:0]           dw_expected;
  logic [3:0]            beat_type;
  logic [10:0]           beat_dw_count;
  logic [11:0]           beat_dw_expected;
  logic [KEEP_WIDTH-1:0] first_keep;
  logic [11:0]           first_lanes;
  logic [11:0]           beat_lanes;
  logic [11:0]           payload_total;
  logic                  unused_tuser;

  function automatic logic [11:0] count_lanes(input logic [KEEP_WIDTH-1:0] keep);
    logic [11:0] n;
    n = '0;
    for (int i = 0; i < KEEP_WIDTH; i++) begin
      n = n + {11'd0, keep[i]};
    end
    return n;
  endfunction

  function automatic logic [11:0] sat_add(input logic [11:0] a, input logic [11:0] b);
    logic [12:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[12] ? 12'hFFF : s[11:0];
  endfunction

  assign unused_tuser = ^m_axis_cq_tuser;

  assign beat_type        = m_axis_cq_tdata[78:75];
  assign beat_dw_count    = m_axis_cq_tdata[74:64];
  // A length field of zero encodes the maximum of 1024 DW.
  assign beat_dw_expected = (beat_dw_count == 11'd0) ? 12'd1024 : {1'b0, beat_dw_count};
  assign first_keep       = m_axis_cq_tkeep & PAYLOAD_LANES;
  assign first_lanes      = count_lanes(first_keep);
  assign beat_lanes       = count_lanes(m_axis_cq_tkeep);
  assign payload_total    = sat_add(dw_seen, beat_lanes);

  assign beat       = m_axis_cq_tvalid && m_axis_cq_tready;
  assign req_done   = !req_valid || req_ready;
  assign wr_done    = !wr_valid || wr_ready;
  assign is_request = (beat_type == TYPE_MEM_RD) || (beat_type == TYPE_MEM_WR);

  // run holds tready low through reset and for the edge that releases it.
  always_comb begin
    m_axis_cq_tready = 1'b0;
    if (run) begin
      case (state)
        IDLE:    m_axis_cq_tready = !req_valid && !wr_valid;
        PAYLOAD: m_axis_cq_tready = !wr_valid || wr_ready;
        DISCARD: m_axis_cq_tready = 1'b1;
        default: m_axis_cq_tready = 1'b0;
      endcase
    end
  end

  always_ff @(posedge user_clk) begin
    if (!user_reset_n) begin
      state               <= IDLE;
      run                 <= 1'b0;
      req_valid           <= 1'b0;
      req_type            <= '0;
      req_addr            <= '0;
      req_dw_count        <= '0;
      req_bar_id          <= '0;
      req_requester_id    <= '0;
      req_tag             <= '0;
      req_tc              <= '0;
      req_lower_addr      <= '0;
      wr_valid            <= 1'b0;
      wr_data             <= '0;
      wr_dw_en            <= '0;
      wr_last             <= 1'b0;
      dw_seen             <= '0;
      dw_expected         <= '0;
      err_unsupported_cnt <= '0;
      err_malformed       <= 1'b0;
    end else begin
      run <= 1'b1;

      if (req_valid && req_ready) begin
        req_valid <= 1'b0;
      end
      if (wr_valid && wr_ready) begin
        wr_valid <= 1'b0;
      end

      if (state == IDLE && beat && is_request) begin
        req_type         <= beat_type;
        req_addr         <= {m_axis_cq_tdata[BAR0_SIZE-1:2], 2'b00};
        req_dw_count     <= beat_dw_count;
        req_bar_id       <= m_axis_cq_tdata[114:112];
        req_requester_id <= m_axis_cq_tdata[95:80];
        req_tag          <= m_axis_cq_tdata[103:96];
        req_tc           <= m_axis_cq_tdata[123:121];
        req_lower_addr   <= {m_axis_cq_tdata[6:2], 2'b00};
      end

      case (state)
        IDLE: begin
          if (beat) begin
            case (beat_type)
              TYPE_MEM_RD: begin
                req_valid <= 1'b1;
                state     <= HOLD;
              end
              TYPE_MEM_WR: begin
                req_valid   <= 1'b1;
                wr_valid    <= 1'b1;
                wr_data     <= m_axis_cq_tdata;
                wr_dw_en    <= first_keep;
                wr_last     <= m_axis_cq_tlast;
                dw_seen     <= first_lanes;
                dw_expected <= beat_dw_expected;
                if (m_axis_cq_tlast) begin
                  if (first_lanes != beat_dw_expected) begin
                    err_malformed <= 1'b1;
                  end
                  state <= HOLD;
                end else begin
                  state <= PAYLOAD;
                end
              end
              default: begin
                if (err_unsupported_cnt != 16'hFFFF) begin
                  err_unsupported_cnt <= err_unsupported_cnt + 16'd1;
                end
                state <= m_axis_cq_tlast ? IDLE : DISCARD;
              end
            endcase
          end
        end

        PAYLOAD: begin
          if (beat) begin
            wr_valid <= 1'b1;
            wr_data  <= m_axis_cq_tdata;
            wr_dw_en <= m_axis_cq_tkeep;
            wr_last  <= m_axis_cq_tlast;
            dw_seen  <= payload_total;
            if (m_axis_cq_tlast) begin
              if (payload_total != dw_expected) begin
                err_malformed <= 1'b1;
              end
              state <= HOLD;
            end
          end
        end

        HOLD: begin
          if (req_done && wr_done) begin
            state <= IDLE;
          end
        end

        DISCARD: begin
          if (beat && m_axis_cq_tlast) begin
            state <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cq_parser_mb.sv
// Directed bench for cq_parser_mb: hand-built CQ TLPs with expected request and
// payload fields written out per test.
module tb_cq_parser_mb;

  logic         user_clk = 1'b0;
  logic         user_reset_n;
  logic [255:0] m_axis_cq_tdata;
  logic         m_axis_cq_tvalid;
  logic [84:0]  m_axis_cq_tuser;
  logic [7:0]   m_axis_cq_tkeep;
  logic         m_axis_cq_tlast;
  logic         m_axis_cq_tready;
  logic         req_valid;
  logic         req_ready;
  logic [3:0]   req_type;
  logic [15:0]  req_addr;
  logic [10:0]  req_dw_count;
  logic [2:0]   req_bar_id;
  logic [15:0]  req_requester_id;
  logic [7:0]   req_tag;
  logic [2:0]   req_tc;
  logic [6:0]   req_lower_addr;
  logic         wr_valid;
  logic         wr_ready;
  logic [255:0] wr_data;
  logic [7:0]   wr_dw_en;
  logic         wr_last;
  logic [15:0]  err_unsupported_cnt;
  logic         err_malformed;

  logic wr_ready_cfg;
  logic toggle_en;
  logic tog_val = 1'b1;

  int check_count = 0;
  int error_count = 0;

  typedef struct {
    logic [255:0] data;
    logic [7:0]   en;
    logic         last;
  } wr_beat_t;

  wr_beat_t     wr_q[$];
  wr_beat_t     mon_beat;
  int           req_seen;
  int           wr_seen;
  logic         stall_chk;
  logic [255:0] exp_data[3];

  always #5 user_clk = ~user_clk;

  assign wr_ready = toggle_en ? tog_val : wr_ready_cfg;

  cq_parser_mb dut (
    .user_clk            (user_clk),
    .user_reset_n        (user_reset_n),
    .m_axis_cq_tdata     (m_axis_cq_tdata),
    .m_axis_cq_tvalid    (m_axis_cq_tvalid),
    .m_axis_cq_tuser     (m_axis_cq_tuser),
    .m_axis_cq_tkeep     (m_axis_cq_tkeep),
    .m_axis_cq_tlast     (m_axis_cq_tlast),
    .m_axis_cq_tready    (m_axis_cq_tready),
    .req_valid           (req_valid),
    .req_ready           (req_ready),
    .req_type            (req_type),
    .req_addr            (req_addr),
    .req_dw_count        (req_dw_count),
    .req_bar_id          (req_bar_id),
    .req_requester_id    (req_requester_id),
    .req_tag             (req_tag),
    .req_tc              (req_tc),
    .req_lower_addr      (req_lower_addr),
    .wr_valid            (wr_valid),
    .wr_ready            (wr_ready),
    .wr_data             (wr_data),
    .wr_dw_en            (wr_dw_en),
    .wr_last             (wr_last),
    .err_unsupported_cnt (err_unsupported_cnt),
    .err_malformed       (err_malformed)
  );

  task automatic checkOutput(input string tag, input logic [255:0] observed,
                             input logic [255:0] expected);
    check_count++;
    if (observed !== expected) begin
      error_count++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  function automatic logic [255:0] makeDesc(input logic [15:0] addr, input logic [10:0] dwc,
                                            input logic [3:0] typ, input logic [15:0] rid,
                                            input logic [7:0] tag, input logic [2:0] bar,
                                            input logic [2:0] tc);
    logic [255:0] d;
    d = '0;
    d[15:0]    = addr;
    d[74:64]   = dwc;
    d[78:75]   = typ;
    d[95:80]   = rid;
    d[103:96]  = tag;
    d[114:112] = bar;
    d[123:121] = tc;
    return d;
  endfunction

  // Wrapper alternates wr_ready once per cycle while toggle_en is set.
  always @(negedge user_clk) begin
    if (toggle_en) tog_val = ~tog_val;
    else           tog_val = 1'b1;
  end

  // Handshake monitor: inputs settle at the negedge, so +2 sees what the next posedge samples.
  always @(negedge user_clk) begin
    #2;
    if (user_reset_n) begin
      if (req_valid) req_seen++;
      if (wr_valid)  wr_seen++;
      if (stall_chk && wr_valid && wr_q.size() < 3)
        checkOutput("wr_data_in_order", wr_data, exp_data[wr_q.size()]);
      if (wr_valid && wr_ready) begin
        mon_beat.data = wr_data;
        mon_beat.en   = wr_dw_en;
        mon_beat.last = wr_last;
        wr_q.push_back(mon_beat);
      end
    end
  end

  task automatic applyStimulus(input logic [255:0] d, input logic [7:0] k, input logic l);
    logic acc;
    acc = 1'b0;
    m_axis_cq_tdata  = d;
    m_axis_cq_tkeep  = k;
    m_axis_cq_tlast  = l;
    m_axis_cq_tvalid = 1'b1;
    for (int n = 0; n < 40 && !acc; n++) begin
      #1 acc = m_axis_cq_tready;
      @(negedge user_clk);
    end
    m_axis_cq_tvalid = 1'b0;
    if (!acc) checkOutput("beat_accept_timeout", 256'd0, 256'd1);
  endtask

  task automatic waitIdle();
    logic done;
    done = 1'b0;
    for (int n = 0; n < 100 && !done; n++) begin
      #1 done = m_axis_cq_tready && !req_valid && !wr_valid;
      @(negedge user_clk);
    end
    if (!done) checkOutput("idle_timeout", 256'd0, 256'd1);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [255:0] d;
    user_reset_n     = 1'b0;
    m_axis_cq_tdata  = '0;
    m_axis_cq_tvalid = 1'b0;
    m_axis_cq_tuser  = '0;
    m_axis_cq_tkeep  = '0;
    m_axis_cq_tlast  = 1'b0;
    req_ready        = 1'b1;
    wr_ready_cfg     = 1'b1;
    toggle_en        = 1'b0;
    stall_chk        = 1'b0;
    req_seen         = 0;
    wr_seen          = 0;

    // Reset values
    repeat (3) @(negedge user_clk);
    checkOutput("rst_tready",    m_axis_cq_tready,    0);
    checkOutput("rst_req_valid", req_valid,           0);
    checkOutput("rst_wr_valid",  wr_valid,            0);
    checkOutput("rst_wr_last",   wr_last,             0);
    checkOutput("rst_err_cnt",   err_unsupported_cnt, 0);
    checkOutput("rst_malformed", err_malformed,       0);
    checkOutput("rst_req_addr",  req_addr,            0);
    checkOutput("rst_wr_data",   wr_data,             0);
    user_reset_n = 1'b1;
    @(negedge user_clk);
    checkOutput("tready_after_release", m_axis_cq_tready, 1);

    // MemRd held by req_ready=0
    $display("[TB] MemRd with stalled req_ready");
    req_ready = 1'b0;
    applyStimulus(makeDesc(16'h0104, 11'd2, 4'b0000, 16'hABCD, 8'h5A, 3'd2, 3'd5), 8'h0F, 1'b1);
    checkOutput("rd_req_valid",  req_valid,        1);
    checkOutput("rd_req_addr",   req_addr,         16'h0104);
    checkOutput("rd_lower_addr", req_lower_addr,   7'h04);
    checkOutput("rd_tag",        req_tag,          8'h5A);
    checkOutput("rd_dw_count",   req_dw_count,     11'd2);
    checkOutput("rd_type",       req_type,         4'b0000);
    checkOutput("rd_req_id",     req_requester_id, 16'hABCD);
    checkOutput("rd_bar",        req_bar_id,       3'd2);
    checkOutput("rd_tc",         req_tc,           3'd5);
    checkOutput("rd_wr_valid",   wr_valid,         0);
    checkOutput("rd_tready_low", m_axis_cq_tready, 0);
    repeat (2) @(negedge user_clk);
    checkOutput("rd_req_valid_hold", req_valid,        1);
    checkOutput("rd_tready_hold",    m_axis_cq_tready, 0);
    checkOutput("rd_tag_hold",       req_tag,          8'h5A);
    req_ready = 1'b1;
    @(negedge user_clk);
    checkOutput("rd_req_valid_done", req_valid,        0);
    checkOutput("rd_tready_back",    m_axis_cq_tready, 1);

    // Single-beat MemWr, wr channel stalled one extra cycle
    $display("[TB] single-beat MemWr");
    wr_ready_cfg = 1'b0;
    d = makeDesc(16'h0040, 11'd2, 4'b0001, 16'h0100, 8'h11, 3'd0, 3'd0);
    d[191:128] = 64'h1122334455667788;
    applyStimulus(d, 8'h3F, 1'b1);
    checkOutput("wr1_req_valid", req_valid,       1);
    checkOutput("wr1_wr_valid",  wr_valid,        1);
    checkOutput("wr1_dw_en",     wr_dw_en,        8'h30);
    checkOutput("wr1_payload",   wr_data[191:128], 64'h1122334455667788);
    checkOutput("wr1_last",      wr_last,         1);
    checkOutput("wr1_malformed", err_malformed,   0);
    checkOutput("wr1_type",      req_type,        4'b0001);
    @(negedge user_clk);
    checkOutput("wr1_req_done",     req_valid,        0);
    checkOutput("wr1_wr_held",      wr_valid,         1);
    checkOutput("wr1_payload_held", wr_data[191:128], 64'h1122334455667788);
    checkOutput("wr1_tready_hold",  m_axis_cq_tready, 0);
    wr_ready_cfg = 1'b1;
    @(negedge user_clk);
    checkOutput("wr1_wr_done", wr_valid,         0);
    checkOutput("wr1_tready",  m_axis_cq_tready, 1);

    // Three-beat MemWr with wr_ready toggling
    $display("[TB] three-beat MemWr with toggling wr_ready");
    wr_q.delete();
    exp_data[0] = makeDesc(16'h0200, 11'd20, 4'b0001, 16'h0200, 8'h22, 3'd1, 3'd0);
    exp_data[0][255:128] = 128'hA3A3A3A3_A2A2A2A2_A1A1A1A1_A0A0A0A0;
    exp_data[1] = {8{32'hB000_0001}};
    exp_data[2] = {8{32'hC000_0002}};
    toggle_en = 1'b1;
    stall_chk = 1'b1;
    applyStimulus(exp_data[0], 8'hFF, 1'b0);
    applyStimulus(exp_data[1], 8'hFF, 1'b0);
    applyStimulus(exp_data[2], 8'hFF, 1'b1);
    waitIdle();
    toggle_en = 1'b0;
    stall_chk = 1'b0;
    checkOutput("wr3_beats", wr_q.size(), 3);
    for (int i = 0; i < 3; i++) begin
      if (i < wr_q.size()) begin
        checkOutput($sformatf("wr3_data%0d", i), wr_q[i].data, exp_data[i]);
        checkOutput($sformatf("wr3_en%0d", i),   wr_q[i].en,   (i == 0) ? 8'hF0 : 8'hFF);
        checkOutput($sformatf("wr3_last%0d", i), wr_q[i].last, (i == 2) ? 1'b1 : 1'b0);
      end
    end
    checkOutput("wr3_malformed", err_malformed, 0);

    // dw_count 0 means 1024 DW: 4 + 127*8 + 4
    $display("[TB] MemWr with dw_count 0");
    wr_q.delete();
    applyStimulus(makeDesc(16'h1000, 11'd0, 4'b0001, 16'h0300, 8'h44, 3'd0, 3'd0), 8'hFF, 1'b0);
    for (int i = 0; i < 127; i++) applyStimulus({8{i[31:0]}}, 8'hFF, 1'b0);
    applyStimulus({8{32'hEEEE_EEEE}}, 8'h0F, 1'b1);
    waitIdle();
    checkOutput("dw1024_beats",     wr_q.size(),   129);
    checkOutput("dw1024_malformed", err_malformed, 0);

    // Unsupported type then MemRd
    $display("[TB] unsupported TLP then MemRd");
    req_seen = 0;
    wr_seen  = 0;
    applyStimulus(makeDesc(16'h0300, 11'd4, 4'b0010, 16'h0400, 8'h99, 3'd0, 3'd0), 8'hFF, 1'b0);
    applyStimulus({8{32'hDEAD_0001}}, 8'hFF, 1'b0);
    applyStimulus({8{32'hDEAD_0002}}, 8'hFF, 1'b1);
    @(negedge user_clk);
    checkOutput("unsup_req_seen", req_seen,            0);
    checkOutput("unsup_wr_seen",  wr_seen,             0);
    checkOutput("unsup_cnt",      err_unsupported_cnt, 16'd1);
    checkOutput("unsup_tready",   m_axis_cq_tready,    1);
    applyStimulus(makeDesc(16'h0208, 11'd1, 4'b0000, 16'h0500, 8'h33, 3'd0, 3'd0), 8'h0F, 1'b1);
    checkOutput("rd2_req_valid",  req_valid,      1);
    checkOutput("rd2_tag",        req_tag,        8'h33);
    checkOutput("rd2_addr",       req_addr,       16'h0208);
    checkOutput("rd2_lower_addr", req_lower_addr, 7'h08);
    checkOutput("rd2_type",       req_type,       4'b0000);
    waitIdle();

    // Short MemWr: dw_count 8, only 4 DW delivered
    $display("[TB] malformed MemWr");
    wr_q.delete();
    d = makeDesc(16'h0400, 11'd8, 4'b0001, 16'h0600, 8'h55, 3'd0, 3'd0);
    d[191:128] = 64'h0000_0002_0000_0001;
    applyStimulus(d, 8'h3F, 1'b0);
    applyStimulus({8{32'h0000_0005}}, 8'h03, 1'b1);
    checkOutput("mal_wr_last",   wr_last,       1);
    checkOutput("mal_dw_en",     wr_dw_en,      8'h03);
    checkOutput("mal_malformed", err_malformed, 1);
    waitIdle();
    checkOutput("mal_beats", wr_q.size(), 2);
    if (wr_q.size() == 2) begin
      checkOutput("mal_last0", wr_q[0].last, 0);
      checkOutput("mal_last1", wr_q[1].last, 1);
      checkOutput("mal_en0",   wr_q[0].en,   8'h30);
    end
    user_reset_n = 1'b0;
    repeat (2) @(negedge user_clk);
    checkOutput("mal_rst_malformed", err_malformed,       0);
    checkOutput("mal_rst_cnt",       err_unsupported_cnt, 0);
    user_reset_n = 1'b1;
    @(negedge user_clk);

    // Reset during the second beat of a MemWr
    $display("[TB] reset mid-payload");
    applyStimulus(makeDesc(16'h0500, 11'd24, 4'b0001, 16'h0700, 8'h66, 3'd0, 3'd0), 8'hFF, 1'b0);
    checkOutput("midrst_wr_valid_pre", wr_valid, 1);
    m_axis_cq_tdata  = {8{32'h0000_0077}};
    m_axis_cq_tkeep  = 8'hFF;
    m_axis_cq_tlast  = 1'b0;
    m_axis_cq_tvalid = 1'b1;
    user_reset_n     = 1'b0;
    @(negedge user_clk);
    checkOutput("midrst_wr_valid",  wr_valid,         0);
    checkOutput("midrst_req_valid", req_valid,        0);
    checkOutput("midrst_wr_last",   wr_last,          0);
    checkOutput("midrst_tready",    m_axis_cq_tready, 0);
    m_axis_cq_tvalid = 1'b0;
    user_reset_n     = 1'b1;
    @(negedge user_clk);
    checkOutput("midrst_idle_tready", m_axis_cq_tready, 1);
    applyStimulus(makeDesc(16'h0010, 11'd1, 4'b0000, 16'h0800, 8'h77, 3'd3, 3'd1), 8'h0F, 1'b1);
    checkOutput("rd3_req_valid",  req_valid,      1);
    checkOutput("rd3_tag",        req_tag,        8'h77);
    checkOutput("rd3_addr",       req_addr,       16'h0010);
    checkOutput("rd3_lower_addr", req_lower_addr, 7'h10);
    checkOutput("rd3_bar",        req_bar_id,     3'd3);
    checkOutput("rd3_wr_valid",   wr_valid,       0);
    waitIdle();

    $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
    $finish;
  end

endmodule

// File: doc/cq_parser_mb.md
CQ_PARSER_MB -- requirements
Module: cq_parser_mb

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 256, CQ data width; legal 256 or 512.
REQ-002 SHALL have parameter TUSER_WIDTH, default 85, CQ tuser width (183 when DATA_WIDTH=512).
REQ-003 SHALL have parameter BAR0_SIZE, default 16, byte-address width of decoded BAR aperture.
REQ-004 SHALL have ports, clock and reset first: user_clk in 1 sole clock; user_reset_n in 1 synchronous active-low reset.
REQ-005 SHALL have ports m_axis_cq_tdata in DATA_WIDTH; m_axis_cq_tvalid in 1; m_axis_cq_tuser in TUSER_WIDTH (unused); m_axis_cq_tkeep in DATA_WIDTH/32; m_axis_cq_tlast in 1; m_axis_cq_tready out 1.
REQ-006 SHALL have request ports req_valid out 1; req_ready in 1; req_type out 4; req_addr out BAR0_SIZE (DW aligned); req_dw_count out 11; req_bar_id out 3; req_requester_id out 16; req_tag out 8; req_tc out 3; req_lower_addr out 7.
REQ-007 SHALL have write-payload ports wr_valid out 1; wr_ready in 1; wr_data out DATA_WIDTH; wr_dw_en out DATA_WIDTH/32 (per-DW lane enable); wr_last out 1.
REQ-008 SHALL have status ports err_unsupported_cnt out 16 and err_malformed out 1 (sticky).

Function
REQ-009 SHALL decode descriptor fields from the first beat exactly as: addr={tdata[BAR0_SIZE-1:2],2'b00}, dw_count=tdata[74:64], type=tdata[78:75], requester_id=tdata[95:80], tag=tdata[103:96], bar_id=tdata[114:112], tc=tdata[123:121], lower_addr={tdata[6:2],2'b00}.
REQ-010 SHALL implement FSM states IDLE, HOLD, PAYLOAD, DISCARD.
REQ-011 IDLE: tready=1 when req_valid=0 and wr_valid=0; beat accepted (tvalid&tready) is first beat of a TLP.
REQ-012 IDLE, type 0000 (MemRd): register descriptor, req_valid=1 next cycle, go HOLD; tready=0 until req handshake completes, then IDLE.
REQ-013 IDLE, type 0001 (MemWr): register descriptor and first beat; next cycle req_valid=1 and wr_valid=1 together, wr_dw_en lanes 0..3=0, lanes 4..N set from tkeep; wr_last=tlast.
REQ-014 MemWr with tlast=0 on first beat SHALL go PAYLOAD; with tlast=1 SHALL go HOLD until both req and wr handshakes complete, then IDLE.
REQ-015 PAYLOAD: tready = !wr_valid | wr_ready (single output register, no bubbles under continuous wr_ready); each accepted beat forwarded one cycle later with wr_dw_en=tkeep, wr_last=tlast; after tlast beat accepted go HOLD.
REQ-016 req and wr channels SHALL handshake independently; each valid SHALL stay asserted with stable data until its ready is sampled high.
REQ-017 Any other type SHALL: not assert req_valid or wr_valid; increment err_unsupported_cnt by 1 saturating at 16'hFFFF; go DISCARD if tlast=0 else stay IDLE.
REQ-018 DISCARD: tready=1, drop beats, return IDLE after tlast beat.
REQ-019 MemWr where tlast arrives with total enabled DW count != dw_count (dw_count 0 treated as 1024) SHALL set err_malformed=1; payload still forwarded, wr_last on tlast beat.
REQ-020 tvalid=0 mid-packet SHALL stall the FSM without state change; tready SHALL never depend combinationally on tvalid.
REQ-021 Latency: tvalid&tready to req_valid/wr_valid exactly 1 cycle.

Reset
REQ-022 With user_reset_n=0 at a clock edge: state=IDLE, req_valid=0, wr_valid=0, wr_last=0, tready=0, err_unsupported_cnt=0, err_malformed=0; data outputs 0.
REQ-023 tready SHALL go 1 the first cycle after user_reset_n returns 1.
REQ-024 Reset mid-packet SHALL abandon the packet; subsequent beat after reset treated as first beat.

Verification
REQ-025 MemRd, tag 8'h5A, addr 16'h0104, dw_count 2 -> req_valid 1 cycle later, req_addr 16'h0104, req_lower_addr 7'h04, tready low until req_ready.
REQ-026 MemWr 1 beat, dw_count 2, tkeep 8'h3F, payload 64'h1122334455667788 -> wr_dw_en 8'h30, wr_data[191:128]=payload, wr_last=1, err_malformed=0.
REQ-027 MemWr 3 beats, dw_count 20, wr_ready toggling 1010 -> all 3 beats delivered in order, unchanged while stalled, single wr_last.
REQ-028 Type 4'b0010 3-beat TLP then MemRd -> no req/wr valids for first TLP, err_unsupported_cnt=1, MemRd decoded normally.
REQ-029 MemWr dw_count 8 terminated after 4 DW -> err_malformed=1, wr_last on tlast beat; reset -> err_malformed=0.
REQ-030 Reset asserted during PAYLOAD beat 2 -> wr_valid=0, state IDLE; next MemRd decoded correctly.
